hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter AW, default 3, register-address width.
REQ-002 SHALL have parameter NSRC, default 2, source operands per instruction (1..4).
REQ-003 SHALL have parameter LOAD_LAT, default 1, data-memory load latency in cycles (1..16).
REQ-004 SHALL have parameter ZERO_REG, default 0; when 1, register 0 never causes a forward or stall.
REQ-005 SHALL have parameter CW, default 16, statistics counter width.
REQ-006 Ports:
  clk  in  1  clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  id_rs  in  NSRC*AW  ID-stage source registers, operand k at [k*AW +: AW]
  id_rs_used  in  NSRC  per-operand read enable, ID stage
  ex_valid, ex_reg_write, ex_mem_read  in  1 each  EX-stage qualifiers
  ex_rd  in  AW  EX destination
  ex_rs  in  NSRC*AW  EX-stage source registers
  mem_valid, mem_reg_write, mem_mem_read  in  1 each  MEM-stage qualifiers
  mem_rd  in  AW  MEM destination
  wb_valid, wb_reg_write  in  1 each  WB-stage qualifiers
  wb_rd  in  AW  WB destination
  fwd_sel  out  2*NSRC  per-operand select: 00 register file, 01 MEM, 10 WB
  stall_pc, stall_ifid  out  1 each  hold PC and IF/ID register
  bubble_idex  out  1  load a NOP into ID/EX
  freeze  out  1  hold all pipeline registers
  lu_stall_cnt, freeze_cnt  out  CW each  saturating statistics

Function
REQ-007 fwd_sel[k] SHALL be 01 when mem_valid & mem_reg_write & !mem_mem_read & mem_rd==ex_rs[k].
REQ-008 Otherwise fwd_sel[k] SHALL be 10 when wb_valid & wb_reg_write & wb_rd==ex_rs[k]; else 00 (MEM beats WB).
REQ-009 With ZERO_REG=1, an ex_rs[k] of 0 SHALL give fwd_sel[k]=00.
REQ-010 Load-use hazard (lu) SHALL be: ex_valid & ex_mem_read & ex_reg_write & some k with id_rs_used[k] & id_rs[k]==ex_rd (excluding 0 when ZERO_REG=1).
REQ-011 stall_pc, stall_ifid, bubble_idex SHALL equal lu & !freeze, combinationally, same cycle.
REQ-012 FSM SHALL have states RUN and MEM_WAIT plus a down-counter wcnt of width ceil(log2(16)).
REQ-013 In RUN with mem_valid & mem_mem_read & LOAD_LAT>1: freeze=1 that cycle; next state MEM_WAIT; wcnt<=LOAD_LAT-2.
REQ-014 In MEM_WAIT: freeze=1 while wcnt!=0, wcnt decrements; at wcnt==0 freeze=0 and next state RUN.
REQ-015 A load therefore SHALL see exactly LOAD_LAT-1 freeze cycles; with LOAD_LAT=1 freeze SHALL be constantly 0 and the FSM stays in RUN.
REQ-016 Back-to-back loads SHALL each receive their full freeze window with no RUN cycle lost beyond one.
REQ-017 When freeze and lu coincide, freeze SHALL win: no bubble, lu re-evaluated after release.
REQ-018 lu_stall_cnt SHALL increment on each cycle bubble_idex=1; freeze_cnt on each cycle freeze=1; both saturate at all-ones.
REQ-019 fwd_sel SHALL be independent of freeze (pure function of current inputs).

Reset
REQ-020 rst_n low SHALL asynchronously force state RUN, wcnt 0, both counters 0.
REQ-021 During and immediately after reset, freeze SHALL be 0 unless REQ-013 applies to current inputs; reset mid-MEM_WAIT SHALL abort the wait.

Structure
REQ-022 Package SHALL hold fwd_sel encodings (FWD_RF, FWD_MEM, FWD_WB) and the FSM state typedef.
REQ-023 Per-operand comparison SHALL be one sub-module, fwd_operand_match, instantiated NSRC times via generate.

Verification
REQ-024 AW=3: mem_rd=3 write, wb_rd=3 write, ex_rs[0]=3 -> fwd_sel[1:0]=01; drop MEM write -> 10.
REQ-025 ex load to r5, id_rs[1]=5 used, LOAD_LAT=1 -> stall_pc=stall_ifid=bubble_idex=1 for 1 cycle, lu_stall_cnt=1.
REQ-026 LOAD_LAT=4, load enters MEM -> freeze high exactly 3 cycles, freeze_cnt=3, state back to RUN.
REQ-027 LOAD_LAT=3, load in MEM plus lu in EX/ID same cycle -> bubble_idex=0 during 2 freeze cycles, then 1 for one cycle.
REQ-028 ZERO_REG=1, all stage rd=0 writing, ex_rs=0 -> fwd_sel=00, no stall.
REQ-029 rst_n low in 2nd cycle of MEM_WAIT (LOAD_LAT=5) -> freeze drops immediately, counters 0; CW=4 run 20 bubbles -> lu_stall_cnt=15.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings and types for the pipeline hazard / forwarding unit.
package hazard_forward_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Wide enough to hold the longest supported load latency (16 cycles).
    localparam int WCNT_W = 4;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hfu_state_t;

endpackage

// File: rtl/hazard_forward_unit_match.sv
// Per-operand register comparison: forwarding select for the EX operand and
// load-use detection for the ID operand.
module fwd_operand_match
    import hazard_forward_unit_pkg::*;
#(
    parameter int AW       = 3,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic [AW-1:0] ex_rs,
    input  logic [AW-1:0] id_rs,
    input  logic          id_rs_used,
    input  logic          mem_fwd_en,
    input  logic [AW-1:0] mem_rd,
    input  logic          wb_fwd_en,
    input  logic [AW-1:0] wb_rd,
    input  logic          lu_en,
    input  logic [AW-1:0] ex_rd,
    output logic [1:0]    fwd_sel,
    output logic          lu_hit
);

    logic ex_rs_ok_s;
    logic id_rs_ok_s;

    // r0 is hard-wired when ZERO_REG is set, so it never matches a producer.
    assign ex_rs_ok_s = !(ZERO_REG && (ex_rs == {AW{1'b0}}));
    assign id_rs_ok_s = !(ZERO_REG && (id_rs == {AW{1'b0}}));

    // Forwarding select: the younger MEM result takes priority over WB.
    always_comb begin
        fwd_sel = FWD_RF;
        if (ex_rs_ok_s && mem_fwd_en && (mem_rd == ex_rs)) begin
            fwd_sel = FWD_MEM;
        end else if (ex_rs_ok_s && wb_fwd_en && (wb_rd == ex_rs)) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

    assign lu_hit = lu_en && id_rs_used && id_rs_ok_s && (id_rs == ex_rd);

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard / forwarding unit: operand forwarding, load-use stall, multi-cycle
// load freeze FSM and saturating statistics counters.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int AW       = 3,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 0,
    parameter int CW       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSRC*AW-1:0] id_rs,
    input  logic [NSRC-1:0]   id_rs_used,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [AW-1:0]     ex_rd,
    input  logic [NSRC*AW-1:0] ex_rs,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [AW-1:0]     mem_rd,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [AW-1:0]     wb_rd,
    output logic [2*NSRC-1:0] fwd_sel,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              freeze,
    output logic [CW-1:0]     lu_stall_cnt,
    output logic [CW-1:0]     freeze_cnt
);

    localparam bit LONG_LOAD = (LOAD_LAT > 32'sd1);
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(LOAD_LAT - 32'sd2);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = {{(WCNT_W-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0]     CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    logic              mem_fwd_en_s;
    logic              wb_fwd_en_s;
    logic              lu_en_s;
    logic [NSRC-1:0]   lu_hit_s;
    logic              lu_s;
    logic              freeze_s;
    logic              bubble_s;
    hfu_state_t        state_r;
    hfu_state_t        state_nxt_s;
    logic [WCNT_W-1:0] wcnt_r;
    logic [WCNT_W-1:0] wcnt_nxt_s;
    logic [CW-1:0]     lu_stall_cnt_r;
    logic [CW-1:0]     freeze_cnt_r;

    // A load in MEM has no data yet, so it is never a forwarding source.
    assign mem_fwd_en_s = mem_valid && mem_reg_write && !mem_mem_read;
    assign wb_fwd_en_s  = wb_valid && wb_reg_write;
    assign lu_en_s      = ex_valid && ex_mem_read && ex_reg_write;

    for (genvar k = 0; k < NSRC; k++) begin : g_operand
        fwd_operand_match #(
            .AW       (AW),
            .ZERO_REG (ZERO_REG[0])
        ) u_match (
            .ex_rs      (ex_rs[k*AW +: AW]),
            .id_rs      (id_rs[k*AW +: AW]),
            .id_rs_used (id_rs_used[k]),
            .mem_fwd_en (mem_fwd_en_s),
            .mem_rd     (mem_rd),
            .wb_fwd_en  (wb_fwd_en_s),
            .wb_rd      (wb_rd),
            .lu_en      (lu_en_s),
            .ex_rd      (ex_rd),
            .fwd_sel    (fwd_sel[2*k +: 2]),
            .lu_hit     (lu_hit_s[k])
        );
    end

    assign lu_s = |lu_hit_s;

    // Freeze FSM: the entry cycle freezes too, so a load sees LOAD_LAT-1 frozen cycles.
    always_comb begin
        state_nxt_s = state_r;
        wcnt_nxt_s  = wcnt_r;
        freeze_s    = 1'b0;
        case (state_r)
            RUN: begin
                if (LONG_LOAD && mem_valid && mem_mem_read) begin
                    freeze_s    = 1'b1;
                    state_nxt_s = MEM_WAIT;
                    wcnt_nxt_s  = WCNT_LOAD;
                end else begin
                    freeze_s    = 1'b0;
                    state_nxt_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (wcnt_r != {WCNT_W{1'b0}}) begin
                    freeze_s   = 1'b1;
                    wcnt_nxt_s = wcnt_r - WCNT_ONE;
                end else begin
                    freeze_s    = 1'b0;
                    state_nxt_s = RUN;
                end
            end
            default: begin
                freeze_s    = 1'b0;
                state_nxt_s = RUN;
                wcnt_nxt_s  = {WCNT_W{1'b0}};
            end
        endcase
    end

    // A freeze holds every stage, so it suppresses the load-use bubble.
    assign bubble_s    = lu_s && !freeze_s;
    assign stall_pc    = bubble_s;
    assign stall_ifid  = bubble_s;
    assign bubble_idex = bubble_s;
    assign freeze      = freeze_s;

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
            wcnt_r  <= {WCNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            wcnt_r  <= wcnt_nxt_s;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_stall_cnt_r <= {CW{1'b0}};
            freeze_cnt_r   <= {CW{1'b0}};
        end else begin
            if (bubble_s && (lu_stall_cnt_r != CNT_MAX)) begin
                lu_stall_cnt_r <= lu_stall_cnt_r + CNT_ONE;
            end
            if (freeze_s && (freeze_cnt_r != CNT_MAX)) begin
                freeze_cnt_r <= freeze_cnt_r + CNT_ONE;
            end
        end
    end

    assign lu_stall_cnt = lu_stall_cnt_r;
    assign freeze_cnt   = freeze_cnt_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: five instances with different
// parameters share one stimulus bus; expectations are hand-computed.
module tb_hazard_forward_unit;

    localparam int NDUT   = 5;
    localparam int D_BASE = 0;  // LOAD_LAT=1
    localparam int D_L4   = 1;  // LOAD_LAT=4
    localparam int D_L3   = 2;  // LOAD_LAT=3
    localparam int D_L5   = 3;  // LOAD_LAT=5, CW=4
    localparam int D_ZR   = 4;  // ZERO_REG=1

    function automatic int ll_of(input int i);
        case (i)
            1:       return 4;
            2:       return 3;
            3:       return 5;
            default: return 1;
        endcase
    endfunction

    function automatic int zr_of(input int i);
        return (i == 4) ? 1 : 0;
    endfunction

    function automatic int cw_of(input int i);
        return (i == 3) ? 4 : 16;
    endfunction

    logic       clk;
    logic       rst_n;
    logic [5:0] id_rs;
    logic [1:0] id_rs_used;
    logic       ex_valid, ex_reg_write, ex_mem_read;
    logic [2:0] ex_rd;
    logic [5:0] ex_rs;
    logic       mem_valid, mem_reg_write, mem_mem_read;
    logic [2:0] mem_rd;
    logic       wb_valid, wb_reg_write;
    logic [2:0] wb_rd;

    logic [3:0]  fwd_o      [NDUT];
    logic        stall_pc_o [NDUT];
    logic        stall_if_o [NDUT];
    logic        bubble_o   [NDUT];
    logic        freeze_o   [NDUT];
    logic [15:0] lu_cnt_o   [NDUT];
    logic [15:0] fz_cnt_o   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int CWG = cw_of(g);
        logic [3:0]     fwd_w;
        logic           spc_w, sif_w, bub_w, frz_w;
        logic [CWG-1:0] lu_w, fz_w;

        hazard_forward_unit #(
            .AW(3), .NSRC(2), .LOAD_LAT(ll_of(g)), .ZERO_REG(zr_of(g)), .CW(CWG)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .id_rs(id_rs), .id_rs_used(id_rs_used),
            .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
            .ex_rd(ex_rd), .ex_rs(ex_rs),
            .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
            .mem_rd(mem_rd),
            .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
            .fwd_sel(fwd_w), .stall_pc(spc_w), .stall_ifid(sif_w), .bubble_idex(bub_w),
            .freeze(frz_w), .lu_stall_cnt(lu_w), .freeze_cnt(fz_w)
        );

        assign fwd_o[g]      = fwd_w;
        assign stall_pc_o[g] = spc_w;
        assign stall_if_o[g] = sif_w;
        assign bubble_o[g]   = bub_w;
        assign freeze_o[g]   = frz_w;
        assign lu_cnt_o[g]   = 16'(lu_w);
        assign fz_cnt_o[g]   = 16'(fz_w);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] id_rs;
        logic [1:0] used;
        logic       ex_v, ex_w, ex_ld;
        logic [2:0] ex_rd;
        logic [5:0] ex_rs;
        logic       mem_v, mem_w, mem_ld;
        logic [2:0] mem_rd;
        logic       wb_v, wb_w;
        logic [2:0] wb_rd;
        logic [3:0] exp_fwd;
        logic       exp_lu;
        logic [3:0] exp_fwd_z;
        logic       exp_lu_z;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 6'o00; id_rs_used = 2'b00;
        ex_valid = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 3'd0; ex_rs = 6'o00;
        mem_valid = 1'b0; mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = 3'd0;
        wb_valid = 1'b0; wb_reg_write = 1'b0; wb_rd = 3'd0;
    endtask

    task automatic apply_vec(input vec_t v);
        id_rs = v.id_rs; id_rs_used = v.used;
        ex_valid = v.ex_v; ex_reg_write = v.ex_w; ex_mem_read = v.ex_ld; ex_rd = v.ex_rd;
        ex_rs = v.ex_rs;
        mem_valid = v.mem_v; mem_reg_write = v.mem_w; mem_mem_read = v.mem_ld; mem_rd = v.mem_rd;
        wb_valid = v.wb_v; wb_reg_write = v.wb_w; wb_rd = v.wb_rd;
    endtask

    // Load into r5 sitting in EX, with ID reading r5 on operand 1.
    task automatic set_load_use();
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 3'd5;
        id_rs = 6'o51; id_rs_used = 2'b10;
    endtask

    task automatic set_mem_load(input logic [2:0] rd);
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_rd = rd;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;

        // id_rs, used, ex v/w/ld, ex_rd, ex_rs, mem v/w/ld, mem_rd, wb v/w, wb_rd, fwd, lu, fwd_z, lu_z
        vecs[0]  = '{6'o00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 6'o00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[1]  = '{6'o00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 6'o03, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 3'd3, 4'b0001, 1'b0, 4'b0001, 1'b0};
        vecs[2]  = '{6'o00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 6'o03, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 3'd3, 4'b0010, 1'b0, 4'b0010, 1'b0};
        vecs[3]  = '{6'o00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 6'o03, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd3, 4'b0010, 1'b0, 4'b0010, 1'b0};
        vecs[4]  = '{6'o00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 6'o52, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 3'd2, 4'b0110, 1'b0, 4'b0110, 1'b0};
        vecs[5]  = '{6'o00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 6'o55, 1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 3'd5, 4'b1010, 1'b0, 4'b1010, 1'b0};
        vecs[6]  = '{6'o00, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 6'o55, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd5, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[7]  = '{6'o00, 2'b11, 1'b1, 1'b1, 1'b1, 3'd0, 6'o00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 4'b0101, 1'b1, 4'b0000, 1'b0};
        vecs[8]  = '{6'o51, 2'b10, 1'b1, 1'b1, 1'b1, 3'd5, 6'o00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b1, 4'b0000, 1'b1};
        vecs[9]  = '{6'o51, 2'b01, 1'b1, 1'b1, 1'b1, 3'd5, 6'o00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[10] = '{6'o51, 2'b10, 1'b1, 1'b0, 1'b1, 3'd5, 6'o00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[11] = '{6'o51, 2'b10, 1'b1, 1'b1, 1'b0, 3'd5, 6'o00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[12] = '{6'o51, 2'b10, 1'b0, 1'b1, 1'b1, 3'd5, 6'o00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[13] = '{6'o25, 2'b11, 1'b1, 1'b1, 1'b1, 3'd5, 6'o00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b1, 4'b0000, 1'b1};

        // Reset state, including freeze driven combinationally while in reset.
        rst_n = 1'b1;
        clear_inputs();
        #1;
        rst_n = 1'b0;
        #2;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("rst_lu_cnt_%0d", d), 32'(lu_cnt_o[d]), 32'd0);
            chk($sformatf("rst_fz_cnt_%0d", d), 32'(fz_cnt_o[d]), 32'd0);
            chk($sformatf("rst_freeze_%0d", d), 32'(freeze_o[d]), 32'd0);
        end
        set_mem_load(3'd1);
        #1;
        chk("rst_freeze_load_l4", 32'(freeze_o[D_L4]), 32'd1);
        chk("rst_freeze_load_base", 32'(freeze_o[D_BASE]), 32'd0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational forwarding / load-use table.
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            apply_vec(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_fwd", i),     32'(fwd_o[D_BASE]),      32'(vecs[i].exp_fwd));
            chk($sformatf("vec%0d_bubble", i),  32'(bubble_o[D_BASE]),   32'(vecs[i].exp_lu));
            chk($sformatf("vec%0d_stallpc", i), 32'(stall_pc_o[D_BASE]), 32'(vecs[i].exp_lu));
            chk($sformatf("vec%0d_stallif", i), 32'(stall_if_o[D_BASE]), 32'(vecs[i].exp_lu));
            chk($sformatf("vec%0d_fwd_z", i),   32'(fwd_o[D_ZR]),        32'(vecs[i].exp_fwd_z));
            chk($sformatf("vec%0d_bubble_z", i), 32'(bubble_o[D_ZR]),    32'(vecs[i].exp_lu_z));
        end

        // Single-cycle load-use stall with LOAD_LAT=1.
        do_reset();
        @(posedge clk); #1;
        set_load_use();
        @(negedge clk);
        chk("lu_stall_pc", 32'(stall_pc_o[D_BASE]), 32'd1);
        chk("lu_stall_if", 32'(stall_if_o[D_BASE]), 32'd1);
        chk("lu_bubble", 32'(bubble_o[D_BASE]), 32'd1);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("lu_bubble_after", 32'(bubble_o[D_BASE]), 32'd0);
        chk("lu_cnt_one", 32'(lu_cnt_o[D_BASE]), 32'd1);

        // LOAD_LAT=4: one load, then two back-to-back loads; fwd_sel ignores freeze.
        do_reset();
        @(posedge clk); #1;
        set_mem_load(3'd4);
        ex_rs = 6'o04; wb_valid = 1'b1; wb_reg_write = 1'b1; wb_rd = 3'd4;
        pat = 8'b0111_0111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("l4_freeze_c%0d", c), 32'(freeze_o[D_L4]), 32'(pat[c]));
            chk($sformatf("l4_fwd_c%0d", c), 32'(fwd_o[D_L4]), 32'h2);
            chk($sformatf("l1_nofreeze_c%0d", c), 32'(freeze_o[D_BASE]), 32'd0);
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("l4_freeze_idle", 32'(freeze_o[D_L4]), 32'd0);
        chk("l4_fz_cnt_3", 32'(fz_cnt_o[D_L4]), 32'd3);
        @(posedge clk); #1;
        set_mem_load(3'd2);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("l4_b2b_c%0d", c), 32'(freeze_o[D_L4]), 32'(pat[c]));
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("l4_fz_cnt_9", 32'(fz_cnt_o[D_L4]), 32'd9);

        // LOAD_LAT=3: freeze wins over a coincident load-use hazard.
        do_reset();
        @(posedge clk); #1;
        set_mem_load(3'd7);
        set_load_use();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("l3_bubble_c%0d", c), 32'(bubble_o[D_L3]), (c == 2) ? 32'd1 : 32'd0);
            chk($sformatf("l3_stallpc_c%0d", c), 32'(stall_pc_o[D_L3]), (c == 2) ? 32'd1 : 32'd0);
            chk($sformatf("l3_freeze_c%0d", c), 32'(freeze_o[D_L3]), (c < 2) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("l3_bubble_done", 32'(bubble_o[D_L3]), 32'd0);
        chk("l3_lu_cnt", 32'(lu_cnt_o[D_L3]), 32'd1);
        chk("l3_fz_cnt", 32'(fz_cnt_o[D_L3]), 32'd2);

        // LOAD_LAT=5: reset during the second MEM_WAIT cycle aborts the wait.
        do_reset();
        @(posedge clk); #1;
        set_mem_load(3'd6);
        @(negedge clk);
        chk("l5_freeze_run", 32'(freeze_o[D_L5]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l5_freeze_wait1", 32'(freeze_o[D_L5]), 32'd1);
        @(posedge clk); #1;
        chk("l5_freeze_wait2", 32'(freeze_o[D_L5]), 32'd1);
        chk("l5_fz_cnt_pre", 32'(fz_cnt_o[D_L5]), 32'd2);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("l5_freeze_rst", 32'(freeze_o[D_L5]), 32'd0);
        chk("l5_fz_cnt_rst", 32'(fz_cnt_o[D_L5]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("l5_freeze_post_c%0d", c), 32'(freeze_o[D_L5]), 32'd0);
        end

        // 20 consecutive bubbles: CW=4 saturates at 15, CW=16 reaches 20.
        @(posedge clk); #1;
        set_load_use();
        repeat (20) @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        chk("sat_lu_cnt_cw4", 32'(lu_cnt_o[D_L5]), 32'd15);
        chk("sat_lu_cnt_cw16", 32'(lu_cnt_o[D_BASE]), 32'd20);
        chk("sat_fz_cnt_cw4", 32'(fz_cnt_o[D_L5]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
